// File: rtl/mov_branch_ctrl.sv
// Registered move/branch controller: owns the PC, issues register-file writes for moves,
// applies flag-conditioned PC-relative branches with a one-instruction squash, drives output pins.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_RUN    | normal issue: next valid instruction executes
// ST_SQUASH | branch taken last instruction: next valid instruction is discarded
module mov_branch_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2,
    parameter int PC_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [2*ADDR_W-1:0]   addrs,
    input  logic [DATA_W-1:0]     src_data,
    input  logic [DATA_W-1:0]     offset_data,
    input  logic                  carry_flag,
    input  logic                  borrow_flag,
    output logic [PC_W-1:0]       pc,
    output logic                  wr_en,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [DATA_W-1:0]     wr_data,
    output logic                  branch_taken,
    output logic                  out_sel,
    output logic [DATA_W-1:0]     out_pins
);

    typedef enum logic {ST_RUN, ST_SQUASH} state_t;

    localparam logic [ADDR_W-1:0] K_UNCOND = '0;
    localparam logic [ADDR_W-1:0] K_CARRY  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] K_BORROW = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] K_TOGGLE = '1;

    state_t              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                branch_taken_q, branch_taken_d;
    logic                out_sel_q, out_sel_d;
    logic [DATA_W-1:0]   out_pins_q, out_pins_d;

    logic [ADDR_W-1:0]   dst, src;
    logic [PC_W-1:0]     br_off, pc_inc, pc_br;
    logic                take;

    assign dst    = addrs[2*ADDR_W-1:ADDR_W];
    assign src    = addrs[ADDR_W-1:0];
    // Offset register is two's complement; size cast sign-extends or truncates to PC_W.
    assign br_off = PC_W'($signed(offset_data));
    assign pc_inc = pc_q + PC_W'(1);
    assign pc_br  = pc_q + br_off;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_RUN;
            pc_q           <= '0;
            wr_en_q        <= 1'b0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
            branch_taken_q <= 1'b0;
            out_sel_q      <= 1'b0;
            out_pins_q     <= '0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            wr_en_q        <= wr_en_d;
            wr_addr_q      <= wr_addr_d;
            wr_data_q      <= wr_data_d;
            branch_taken_q <= branch_taken_d;
            out_sel_q      <= out_sel_d;
            out_pins_q     <= out_pins_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        wr_en_d        = 1'b0;
        wr_addr_d      = wr_addr_q;
        wr_data_d      = wr_data_q;
        branch_taken_d = 1'b0;
        out_sel_d      = out_sel_q;
        take           = 1'b0;
        out_pins_d     = out_sel_q ? DATA_W'(pc_q) : offset_data;

        if (en) begin
            if (state_q == ST_SQUASH) begin
                state_d = ST_RUN;
            end else if (dst != src) begin
                wr_en_d   = 1'b1;
                wr_addr_d = dst;
                wr_data_d = src_data;
                pc_d      = pc_inc;
            end else begin
                if (src == K_UNCOND)
                    take = 1'b1;
                else if (src == K_CARRY)
                    take = carry_flag;
                else if (src == K_BORROW)
                    take = borrow_flag;

                if (src == K_TOGGLE)
                    out_sel_d = ~out_sel_q;

                if (take) begin
                    pc_d           = pc_br;
                    branch_taken_d = 1'b1;
                    state_d        = ST_SQUASH;
                end else begin
                    pc_d = pc_inc;
                end
            end
        end
    end

    assign pc           = pc_q;
    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign branch_taken = branch_taken_q;
    assign out_sel      = out_sel_q;
    assign out_pins     = out_pins_q;

endmodule

// File: tb/tb_mov_branch_ctrl.sv
// Bench for mov_branch_ctrl: directed vector table, reset/wrap/stall sequences,
// and randomized instructions checked against an integer reference model.
module tb_mov_branch_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] addrs;
    logic [7:0] src_data;
    logic [7:0] offset_data;
    logic       carry_flag;
    logic       borrow_flag;
    logic [7:0] pc;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic       branch_taken;
    logic       out_sel;
    logic [7:0] out_pins;

    int n_tests = 0;
    int n_fail  = 0;

    mov_branch_ctrl #(.DATA_W(8), .ADDR_W(2), .PC_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .addrs        (addrs),
        .src_data     (src_data),
        .offset_data  (offset_data),
        .carry_flag   (carry_flag),
        .borrow_flag  (borrow_flag),
        .pc           (pc),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .branch_taken (branch_taken),
        .out_sel      (out_sel),
        .out_pins     (out_pins)
    );

    always #5 clk = ~clk;

    // Reference model state, plain integers
    int m_pc, m_sel, m_sq, m_we, m_wa, m_wd, m_bt, m_pins;

    task automatic model_reset();
        m_pc = 0; m_sel = 0; m_sq = 0; m_we = 0; m_wa = 0; m_wd = 0; m_bt = 0; m_pins = 0;
    endtask

    task automatic model_step();
        int d, s, off, pins_n;
        bit taken;
        d      = int'(addrs[3:2]);
        s      = int'(addrs[1:0]);
        off    = (offset_data >= 8'd128) ? int'(offset_data) - 256 : int'(offset_data);
        pins_n = (m_sel != 0) ? m_pc : int'(offset_data);
        m_we   = 0;
        m_bt   = 0;
        if (en) begin
            if (m_sq != 0) begin
                m_sq = 0;
            end else if (d != s) begin
                m_we = 1; m_wa = d; m_wd = int'(src_data);
                m_pc = (m_pc + 1) % 256;
            end else begin
                taken = (s == 0) || (s == 1 && carry_flag) || (s == 2 && borrow_flag);
                if (s == 3) m_sel = 1 - m_sel;
                if (taken) begin
                    m_pc = (m_pc + off + 256) % 256;
                    m_bt = 1;
                    m_sq = 1;
                end else begin
                    m_pc = (m_pc + 1) % 256;
                end
            end
        end
        m_pins = pins_n;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, " pc"}, int'(pc), m_pc);
        chk({tag, " wr_en"}, int'(wr_en), m_we);
        chk({tag, " branch_taken"}, int'(branch_taken), m_bt);
        chk({tag, " out_sel"}, int'(out_sel), m_sel);
        chk({tag, " out_pins"}, int'(out_pins), m_pins);
        if (m_we != 0) begin
            chk({tag, " wr_addr"}, int'(wr_addr), m_wa);
            chk({tag, " wr_data"}, int'(wr_data), m_wd);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " pc"}, int'(pc), 0);
        chk({tag, " wr_en"}, int'(wr_en), 0);
        chk({tag, " wr_addr"}, int'(wr_addr), 0);
        chk({tag, " wr_data"}, int'(wr_data), 0);
        chk({tag, " branch_taken"}, int'(branch_taken), 0);
        chk({tag, " out_sel"}, int'(out_sel), 0);
        chk({tag, " out_pins"}, int'(out_pins), 0);
    endtask

    typedef struct {
        logic       en;
        logic [3:0] addrs;
        logic [7:0] src;
        logic [7:0] off;
        logic       cy;
        logic       bw;
        logic [7:0] pc;
        logic       we;
        logic [1:0] wa;
        logic [7:0] wd;
        logic       bt;
        logic       sel;
        logic [7:0] pins;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(logic e, logic [3:0] a, logic [7:0] s, logic [7:0] o,
                                logic c, logic b, logic [7:0] p, logic w, logic [1:0] wa,
                                logic [7:0] wd, logic bt, logic sel, logic [7:0] pins);
        vec_t v;
        v.en = e; v.addrs = a; v.src = s; v.off = o; v.cy = c; v.bw = b;
        v.pc = p; v.we = w; v.wa = wa; v.wd = wd; v.bt = bt; v.sel = sel; v.pins = pins;
        return v;
    endfunction

    initial begin
        // en addrs   src    off    cy bw | pc     we wa wd     bt sel pins
        tbl[0]  = mk(1, 4'b1001, 8'hA5, 8'h00, 0, 0, 8'h01, 1, 2, 8'hA5, 0, 0, 8'h00); // move r1->r2
        tbl[1]  = mk(1, 4'b0000, 8'h00, 8'h0F, 0, 0, 8'h10, 0, 0, 8'h00, 1, 0, 8'h0F); // uncond
        tbl[2]  = mk(0, 4'b1100, 8'h00, 8'h0F, 0, 0, 8'h10, 0, 0, 8'h00, 0, 0, 8'h0F); // stall, squash held
        tbl[3]  = mk(1, 4'b1100, 8'h33, 8'h40, 0, 0, 8'h10, 0, 0, 8'h00, 0, 0, 8'h40); // squashed move
        tbl[4]  = mk(1, 4'b0000, 8'h00, 8'hFC, 0, 0, 8'h0C, 0, 0, 8'h00, 1, 0, 8'hFC); // branch -4
        tbl[5]  = mk(1, 4'b0110, 8'h77, 8'h55, 0, 0, 8'h0C, 0, 0, 8'h00, 0, 0, 8'h55); // squashed
        tbl[6]  = mk(1, 4'b0110, 8'h77, 8'h55, 0, 0, 8'h0D, 1, 1, 8'h77, 0, 0, 8'h55); // move r2->r1
        tbl[7]  = mk(1, 4'b0101, 8'h00, 8'h03, 0, 1, 8'h0E, 0, 0, 8'h00, 0, 0, 8'h03); // carry=0
        tbl[8]  = mk(1, 4'b0101, 8'h00, 8'h03, 1, 0, 8'h11, 0, 0, 8'h00, 1, 0, 8'h03); // carry=1
        tbl[9]  = mk(1, 4'b1010, 8'h00, 8'h03, 0, 1, 8'h11, 0, 0, 8'h00, 0, 0, 8'h03); // squashed
        tbl[10] = mk(1, 4'b1010, 8'h00, 8'h03, 1, 0, 8'h12, 0, 0, 8'h00, 0, 0, 8'h03); // borrow=0
        tbl[11] = mk(1, 4'b1010, 8'h00, 8'h03, 0, 1, 8'h15, 0, 0, 8'h00, 1, 0, 8'h03); // borrow=1
        tbl[12] = mk(0, 4'b1111, 8'h00, 8'h03, 0, 0, 8'h15, 0, 0, 8'h00, 0, 0, 8'h03); // stall
        tbl[13] = mk(1, 4'b1111, 8'h00, 8'h5A, 0, 0, 8'h15, 0, 0, 8'h00, 0, 0, 8'h5A); // squashed toggle
        tbl[14] = mk(1, 4'b1111, 8'h00, 8'h5A, 0, 0, 8'h16, 0, 0, 8'h00, 0, 1, 8'h5A); // toggle ->1
        tbl[15] = mk(0, 4'b0000, 8'h00, 8'h99, 0, 0, 8'h16, 0, 0, 8'h00, 0, 1, 8'h16); // pins show pc
        tbl[16] = mk(1, 4'b1111, 8'h00, 8'h99, 0, 0, 8'h17, 0, 0, 8'h00, 0, 0, 8'h16); // toggle ->0
        tbl[17] = mk(0, 4'b0000, 8'h00, 8'h99, 0, 0, 8'h17, 0, 0, 8'h00, 0, 0, 8'h99); // pins show offset

        rst = 1'b1; en = 1'b0; addrs = '0; src_data = '0; offset_data = '0;
        carry_flag = 1'b0; borrow_flag = 1'b0;
        model_reset();
        #1;
        check_all_zero("por");
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("por_held");
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            en = tbl[i].en; addrs = tbl[i].addrs; src_data = tbl[i].src;
            offset_data = tbl[i].off; carry_flag = tbl[i].cy; borrow_flag = tbl[i].bw;
            tick();
            chk($sformatf("row%0d pc", i), int'(pc), int'(tbl[i].pc));
            chk($sformatf("row%0d wr_en", i), int'(wr_en), int'(tbl[i].we));
            chk($sformatf("row%0d branch_taken", i), int'(branch_taken), int'(tbl[i].bt));
            chk($sformatf("row%0d out_sel", i), int'(out_sel), int'(tbl[i].sel));
            chk($sformatf("row%0d out_pins", i), int'(out_pins), int'(tbl[i].pins));
            if (tbl[i].we) begin
                chk($sformatf("row%0d wr_addr", i), int'(wr_addr), int'(tbl[i].wa));
                chk($sformatf("row%0d wr_data", i), int'(wr_data), int'(tbl[i].wd));
            end
        end

        // Reset asserted in the middle of a move
        en = 1'b1; addrs = 4'b1001; src_data = 8'hC3; offset_data = 8'h21;
        carry_flag = 1'b0; borrow_flag = 1'b0;
        tick();
        chk("pre_rst wr_en", int'(wr_en), 1);
        chk("pre_rst pc", int'(pc), 8'h18);
        #3 rst = 1'b1;
        #1;
        model_reset();
        check_all_zero("mid_rst");
        @(posedge clk);
        #1;
        chk("rst_held wr_en", int'(wr_en), 0);
        en = 1'b0;
        @(negedge clk) rst = 1'b0;
        tick();
        chk("rst_release wr_en", int'(wr_en), 0);
        chk("rst_release pc", int'(pc), 0);

        // Wrap from 0xFF, then stall
        en = 1'b1; addrs = 4'b0000; offset_data = 8'hFF;
        tick();
        chk("wrap br pc", int'(pc), 8'hFF);
        chk("wrap br taken", int'(branch_taken), 1);
        addrs = 4'b1001; src_data = 8'h11;
        tick();
        chk("wrap squash pc", int'(pc), 8'hFF);
        chk("wrap squash wr_en", int'(wr_en), 0);
        tick();
        chk("wrap move pc", int'(pc), 8'h00);
        chk("wrap move wr_en", int'(wr_en), 1);
        chk("wrap move wr_data", int'(wr_data), 8'h11);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("stall%0d pc", i), int'(pc), 0);
            chk($sformatf("stall%0d out_sel", i), int'(out_sel), 0);
            chk($sformatf("stall%0d wr_en", i), int'(wr_en), 0);
        end

        // Randomized instructions against the model
        for (int i = 0; i < 400; i++) begin
            logic [1:0] k;
            en = ($urandom_range(0, 3) != 0);
            addrs = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                k = 2'($urandom_range(0, 3));
                addrs = {k, k};
            end
            src_data    = 8'($urandom_range(0, 255));
            offset_data = 8'($urandom_range(0, 255));
            carry_flag  = 1'($urandom_range(0, 1));
            borrow_flag = 1'($urandom_range(0, 1));
            tick();
            check_model($sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
